// File: rtl/spi_core_sequencer.sv
// Mode-0 SPI master that pops words from the ring buffer core port, shifts them
// out on MOSI while capturing MISO, then writes the received word back.
module spi_core_sequencer #(
   parameter int DATAWIDTH = 8,
   parameter int DIVWIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DIVWIDTH-1:0]  clockDivider,
   input  logic                 transmitDataReady,
   input  logic [DATAWIDTH-1:0] coreOut,
   output logic                 coreRead,
   output logic                 coreWrite,
   output logic [DATAWIDTH-1:0] coreIn,
   output logic                 sclk,
   output logic                 mosi,
   input  logic                 miso,
   output logic                 ssN,
   output logic                 busy,
   output logic [15:0]          transferCount
);

   localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SHIFT,
      S_STORE
   } state_t;

   state_t                r_state;
   logic [DATAWIDTH-1:0]  r_txShift;
   logic [DATAWIDTH-1:0]  r_rxShift;
   logic [BW-1:0]         r_bitCount;
   logic [DIVWIDTH-1:0]   r_divCount;
   logic [DIVWIDTH-1:0]   r_div;
   logic                  r_sclk;
   logic                  r_ssN;
   logic                  r_coreRead;
   logic                  r_coreWrite;
   logic [DATAWIDTH-1:0]  r_coreIn;
   logic [15:0]           r_transferCount;

   logic                  w_req;
   logic                  w_tc;

   assign w_req = enable & transmitDataReady;
   assign w_tc  = (r_divCount == r_div);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_txShift       <= '0;
         r_rxShift       <= '0;
         r_bitCount      <= '0;
         r_divCount      <= '0;
         r_div           <= '0;
         r_sclk          <= 1'b0;
         r_ssN           <= 1'b1;
         r_coreRead      <= 1'b0;
         r_coreWrite     <= 1'b0;
         r_coreIn        <= '0;
         r_transferCount <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ssN <= 1'b1;
               if (w_req) begin
                  r_state    <= S_FETCH;
                  r_coreRead <= 1'b1;
               end
            end
            S_FETCH: begin
               r_coreRead <= 1'b0;
               r_ssN      <= 1'b0;
               r_state    <= S_LOAD;
            end
            S_LOAD: begin
               r_txShift  <= coreOut;
               r_rxShift  <= '0;
               r_bitCount <= '0;
               r_divCount <= '0;
               r_div      <= clockDivider;
               r_state    <= S_SHIFT;
            end
            S_SHIFT: begin
               if (w_tc) begin
                  r_divCount <= '0;
                  r_sclk     <= ~r_sclk;
                  if (!r_sclk) begin
                     r_rxShift <= {r_rxShift[DATAWIDTH-2:0], miso};
                  end else begin
                     r_txShift  <= {r_txShift[DATAWIDTH-2:0], 1'b0};
                     r_bitCount <= r_bitCount + 1'b1;
                     // The last falling edge hands the completed word straight to STORE.
                     if (r_bitCount == LAST_BIT) begin
                        r_state         <= S_STORE;
                        r_coreWrite     <= 1'b1;
                        r_coreIn        <= r_rxShift;
                        r_transferCount <= r_transferCount + 16'd1;
                     end
                  end
               end else begin
                  r_divCount <= r_divCount + 1'b1;
               end
            end
            S_STORE: begin
               r_coreWrite <= 1'b0;
               if (w_req) begin
                  r_state    <= S_FETCH;
                  r_coreRead <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_ssN   <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign coreRead      = r_coreRead;
   assign coreWrite     = r_coreWrite;
   assign coreIn        = r_coreIn;
   assign sclk          = r_sclk;
   assign ssN           = r_ssN;
   assign busy          = (r_state != S_IDLE);
   assign transferCount = r_transferCount;
   assign mosi          = (r_state == S_LOAD) ? coreOut[DATAWIDTH-1] :
                          (r_state == S_IDLE) ? 1'b0 : r_txShift[DATAWIDTH-1];

endmodule

// File: tb/tb_spi_core_sequencer.sv
// Directed bench for spi_core_sequencer: buffer model, MISO slave model and
// table-driven single-word vectors plus back-to-back, enable-drop and reset sequences.
module tb_spi_core_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [7:0]  clockDivider;
   logic        transmitDataReady;
   logic [7:0]  coreOut = 8'h00;
   logic        coreRead;
   logic        coreWrite;
   logic [7:0]  coreIn;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic        ssN;
   logic        busy;
   logic [15:0] transferCount;

   spi_core_sequencer #(.DATAWIDTH(8), .DIVWIDTH(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .clockDivider      (clockDivider),
      .transmitDataReady (transmitDataReady),
      .coreOut           (coreOut),
      .coreRead          (coreRead),
      .coreWrite         (coreWrite),
      .coreIn            (coreIn),
      .sclk              (sclk),
      .mosi              (mosi),
      .miso              (miso),
      .ssN               (ssN),
      .busy              (busy),
      .transferCount     (transferCount)
   );

   always #5 clk = ~clk;

   // Transmit buffer model: words pushed by the stimulus, popped on coreRead.
   logic [7:0] mem [0:63];
   int         n_push = 0;
   int         n_pop  = 0;
   bit         rand_mode = 1'b1;
   bit         rand_tdr  = 1'b0;

   always @(posedge clk) begin
      if (coreRead) begin
         coreOut <= mem[n_pop];
         n_pop   <= n_pop + 1;
      end
   end
   assign transmitDataReady = rand_mode ? rand_tdr : (n_push != n_pop);

   // Slave model: presents pat MSB first, advancing after each sclk fall.
   bit         loopback = 1'b1;
   logic [7:0] pat = 8'h00;
   int         nfall = 0;
   logic       prev_s = 1'b0;

   always @(negedge clk) begin
      if (coreRead) nfall <= 0;
      else if (prev_s && !sclk) nfall <= nfall + 1;
      prev_s <= sclk;
   end
   assign miso = loopback ? mosi : ((nfall < 8) ? pat[3'(7 - nfall)] : 1'b0);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic push(input logic [7:0] w);
      mem[n_push] = w;
      n_push++;
   endtask

   // Observation results
   int         nrd, nwr, both, bitbad, rises, hmin, hmax, lmin, lmax, ssn_mid;
   int         rd_cyc [4];
   int         wr_cyc [4];
   logic [7:0] wr_dat [4];
   logic [7:0] words  [4];
   logic       ssn_c2, ssn_after;

   // Starting at the negedge of cycle 0, observe cycles 1..ncyc at each negedge.
   task automatic run_obs(input int ncyc, input int nexp, input int drop_at);
      int   rises_w;
      int   run;
      logic ps;
      nrd = 0; nwr = 0; both = 0; bitbad = 0; rises = 0; ssn_mid = 0;
      hmin = 1000; hmax = 0; lmin = 1000; lmax = 0;
      ssn_c2 = 1'bx; ssn_after = 1'bx;
      for (int i = 0; i < 4; i++) begin
         rd_cyc[i] = -1; wr_cyc[i] = -1; wr_dat[i] = 8'h00;
      end
      rises_w = 0; run = 0; ps = sclk;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (coreRead && coreWrite) both++;
         if (coreRead && nrd < 4) begin
            rd_cyc[nrd] = c; nrd++; rises_w = 0;
         end
         if (coreWrite && nwr < 4) begin
            wr_cyc[nwr] = c; wr_dat[nwr] = coreIn; nwr++;
         end
         if (sclk !== ps) begin
            if (sclk) begin
               if (rises_w > 0) begin
                  if (run < lmin) lmin = run;
                  if (run > lmax) lmax = run;
               end
               if (nrd > 0 && rises_w < 8) begin
                  if (mosi !== words[nrd-1][3'(7 - rises_w)]) bitbad++;
               end
               rises_w++; rises++;
            end else begin
               if (run < hmin) hmin = run;
               if (run > hmax) hmax = run;
            end
            run = 1;
         end else begin
            run++;
         end
         ps = sclk;
         if (c == 2) ssn_c2 = ssN;
         if (nwr > 0 && c == wr_cyc[nwr-1] + 1) ssn_after = ssN;
         if (nrd > 0 && c > rd_cyc[0] && nwr < nexp && ssN) ssn_mid++;
         if (c == drop_at) enable = 1'b0;
      end
   endtask

   typedef struct {
      int         div;
      logic [7:0] word;
      bit         lb;
      logic [7:0] pat;
      logic [7:0] exp_in;
      int         exp_wr;
   } vec_t;

   vec_t vt [5];
   int   tc0;

   initial begin
      vt[0] = '{0, 8'hA5, 1'b1, 8'h00, 8'hA5, 19};
      vt[1] = '{3, 8'hFF, 1'b0, 8'h3C, 8'h3C, 67};
      vt[2] = '{1, 8'h5A, 1'b0, 8'hC3, 8'hC3, 35};
      vt[3] = '{0, 8'h00, 1'b0, 8'hFF, 8'hFF, 19};
      vt[4] = '{2, 8'h81, 1'b1, 8'h00, 8'h81, 51};

      // Reset held with random inputs
      reset = 1'b0; enable = 1'b0; clockDivider = 8'd0;
      loopback = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         enable       = 1'($urandom_range(0, 1));
         rand_tdr     = 1'($urandom_range(0, 1));
         clockDivider = 8'($urandom_range(0, 255));
         pat          = 8'($urandom_range(0, 255));
         #1;
         chk("rst_sclk", int'(sclk), 0);
         chk("rst_ssN", int'(ssN), 1);
         chk("rst_coreRead", int'(coreRead), 0);
         chk("rst_coreWrite", int'(coreWrite), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_count", int'(transferCount), 0);
         chk("rst_mosi", int'(mosi), 0);
      end
      @(negedge clk);
      rand_mode = 1'b0; enable = 1'b1; clockDivider = 8'd0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      // Table-driven single words
      foreach (vt[v]) begin
         clockDivider = 8'(vt[v].div);
         loopback     = vt[v].lb;
         pat          = vt[v].pat;
         words[0]     = vt[v].word;
         tc0          = int'(transferCount);
         push(vt[v].word);
         run_obs(vt[v].exp_wr + 3, 1, -1);
         chk($sformatf("v%0d_nrd", v), nrd, 1);
         chk($sformatf("v%0d_rd_cyc", v), rd_cyc[0], 1);
         chk($sformatf("v%0d_ssN_c2", v), int'(ssn_c2), 0);
         chk($sformatf("v%0d_nwr", v), nwr, 1);
         chk($sformatf("v%0d_wr_cyc", v), wr_cyc[0], vt[v].exp_wr);
         chk($sformatf("v%0d_coreIn", v), int'(wr_dat[0]), int'(vt[v].exp_in));
         chk($sformatf("v%0d_ssN_after", v), int'(ssn_after), 1);
         chk($sformatf("v%0d_rises", v), rises, 8);
         chk($sformatf("v%0d_mosi_bits", v), bitbad, 0);
         chk($sformatf("v%0d_hi_min", v), hmin, vt[v].div + 1);
         chk($sformatf("v%0d_hi_max", v), hmax, vt[v].div + 1);
         chk($sformatf("v%0d_lo_min", v), lmin, vt[v].div + 1);
         chk($sformatf("v%0d_lo_max", v), lmax, vt[v].div + 1);
         chk($sformatf("v%0d_ssN_mid", v), ssn_mid, 0);
         chk($sformatf("v%0d_both", v), both, 0);
         chk($sformatf("v%0d_count", v), int'(transferCount), (tc0 + 1) % 65536);
         chk($sformatf("v%0d_busy_end", v), int'(busy), 0);
      end

      // Back-to-back, three words
      clockDivider = 8'd0; loopback = 1'b1;
      words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
      tc0 = int'(transferCount);
      push(8'h01); push(8'h02); push(8'h03);
      run_obs(60, 3, -1);
      chk("b2b_nrd", nrd, 3);
      chk("b2b_rd0", rd_cyc[0], 1);
      chk("b2b_rd1", rd_cyc[1], 20);
      chk("b2b_rd2", rd_cyc[2], 39);
      chk("b2b_nwr", nwr, 3);
      chk("b2b_wr0", wr_cyc[0], 19);
      chk("b2b_wr1", wr_cyc[1], 38);
      chk("b2b_wr2", wr_cyc[2], 57);
      chk("b2b_d0", int'(wr_dat[0]), 8'h01);
      chk("b2b_d1", int'(wr_dat[1]), 8'h02);
      chk("b2b_d2", int'(wr_dat[2]), 8'h03);
      chk("b2b_ssN_mid", ssn_mid, 0);
      chk("b2b_ssN_after", int'(ssn_after), 1);
      chk("b2b_both", both, 0);
      chk("b2b_mosi_bits", bitbad, 0);
      chk("b2b_rises", rises, 24);
      chk("b2b_count", int'(transferCount), (tc0 + 3) % 65536);

      // Enable dropped during the first word's SHIFT
      words[0] = 8'h96;
      tc0 = int'(transferCount);
      push(8'h96); push(8'h69);
      run_obs(40, 1, 8);
      chk("endrop_nrd", nrd, 1);
      chk("endrop_nwr", nwr, 1);
      chk("endrop_wr", wr_cyc[0], 19);
      chk("endrop_data", int'(wr_dat[0]), 8'h96);
      chk("endrop_ssN_after", int'(ssn_after), 1);
      chk("endrop_busy", int'(busy), 0);
      chk("endrop_count", int'(transferCount), (tc0 + 1) % 65536);
      enable = 1'b1;
      words[0] = 8'h69;
      run_obs(22, 1, -1);
      chk("resume_rd", rd_cyc[0], 1);
      chk("resume_wr", wr_cyc[0], 19);
      chk("resume_data", int'(wr_dat[0]), 8'h69);

      // Reset during bit 4 of SHIFT
      words[0] = 8'hC3;
      push(8'hC3);
      run_obs(12, 1, -1);
      chk("mid_busy", int'(busy), 1);
      chk("mid_sclk_hi", int'(sclk), 1);
      reset = 1'b0;
      #1;
      chk("arst_sclk", int'(sclk), 0);
      chk("arst_ssN", int'(ssN), 1);
      chk("arst_busy", int'(busy), 0);
      chk("arst_mosi", int'(mosi), 0);
      chk("arst_count", int'(transferCount), 0);
      chk("arst_coreIn", int'(coreIn), 0);
      push(8'h3C);
      nwr = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (coreWrite) nwr++;
      end
      chk("arst_no_write", nwr, 0);
      reset = 1'b1;
      words[0] = 8'h3C;
      run_obs(22, 1, -1);
      chk("post_rst_rd", rd_cyc[0], 1);
      chk("post_rst_nwr", nwr, 1);
      chk("post_rst_wr", wr_cyc[0], 19);
      chk("post_rst_data", int'(wr_dat[0]), 8'h3C);
      chk("post_rst_count", int'(transferCount), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
